// File: rtl/decode_viterbi.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) convolutional code.
// Four-state add-compare-select with normalized metrics and register-exchange survivors.
module decode_viterbi #(
   parameter int TB_DEPTH = 10,
   parameter int METRIC_W = 6
) (
   input  logic       clk_sig,
   input  logic       reset_sig,
   input  logic [1:0] encode_sig,
   input  logic       valid_sig,
   output logic       decode_sig,
   output logic       decode_valid_sig
);

   localparam logic [METRIC_W-1:0] INIT_M = {1'b1, {(METRIC_W-1){1'b0}}};

   function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
      logic [1:0] d;
      d = rx ^ ex;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

   function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                   input logic [1:0]          b);
      logic [METRIC_W:0] s;
      s = {1'b0, m} + {{(METRIC_W-1){1'b0}}, b};
      return s[METRIC_W] ? {METRIC_W{1'b1}} : s[METRIC_W-1:0];
   endfunction

   function automatic logic [METRIC_W-1:0] min2(input logic [METRIC_W-1:0] a,
                                                input logic [METRIC_W-1:0] b);
      return (b < a) ? b : a;
   endfunction

   logic [METRIC_W-1:0] r_metric [4];
   logic [TB_DEPTH-1:0] r_surv   [4];
   logic [4:0]          r_fill;
   logic                r_decode_p1;
   logic                r_decode_vld_p1;

   logic [METRIC_W-1:0] w_acs      [4];
   logic [METRIC_W-1:0] w_norm     [4];
   logic [TB_DEPTH-1:0] w_surv_nxt [4];
   logic                w_sel      [4];
   logic [METRIC_W-1:0] w_min;
   logic [METRIC_W-1:0] w_best_m;
   logic [1:0]          w_best_idx;
   logic                w_filled;

   // New state {q,s1} chooses between predecessors {s1,0} and {s1,1}; ties keep {s1,0}.
   for (genvar g = 0; g < 4; g++) begin : g_acs
      localparam logic       Q    = ((g >> 1) & 1) != 0;
      localparam logic       S1   = (g & 1) != 0;
      localparam int         P0   = (g & 1) * 2;
      localparam int         P1   = P0 + 1;
      localparam logic [1:0] EXP0 = {Q ^ S1, Q};
      localparam logic [1:0] EXP1 = {~(Q ^ S1), ~Q};

      logic [METRIC_W-1:0] w_sum0;
      logic [METRIC_W-1:0] w_sum1;

      assign w_sum0        = sat_add(r_metric[P0], branch_metric(encode_sig, EXP0));
      assign w_sum1        = sat_add(r_metric[P1], branch_metric(encode_sig, EXP1));
      assign w_sel[g]      = (w_sum1 < w_sum0);
      assign w_acs[g]      = w_sel[g] ? w_sum1 : w_sum0;
      assign w_surv_nxt[g] = w_sel[g] ? {r_surv[P1][TB_DEPTH-2:0], Q}
                                      : {r_surv[P0][TB_DEPTH-2:0], Q};
      assign w_norm[g]     = w_acs[g] - w_min;
   end

   assign w_min    = min2(min2(w_acs[0], w_acs[1]), min2(w_acs[2], w_acs[3]));
   assign w_filled = (r_fill == 5'(TB_DEPTH));

   // Decision uses the metrics and survivors as they stood before this symbol.
   always_comb begin
      w_best_idx = 2'd0;
      w_best_m   = r_metric[0];
      for (int i = 1; i < 4; i++) begin
         if (r_metric[i] < w_best_m) begin
            w_best_m   = r_metric[i];
            w_best_idx = 2'(i);
         end
      end
   end

   always_ff @(posedge clk_sig or posedge reset_sig) begin
      if (reset_sig) begin
         for (int i = 0; i < 4; i++) begin
            r_metric[i] <= (i == 0) ? '0 : INIT_M;
            r_surv[i]   <= '0;
         end
         r_fill          <= '0;
         r_decode_p1     <= 1'b0;
         r_decode_vld_p1 <= 1'b0;
      end else begin
         r_decode_vld_p1 <= 1'b0;
         if (valid_sig) begin
            for (int i = 0; i < 4; i++) begin
               r_metric[i] <= w_norm[i];
               r_surv[i]   <= w_surv_nxt[i];
            end
            if (!w_filled) begin
               r_fill <= r_fill + 5'd1;
            end else begin
               r_decode_p1     <= r_surv[w_best_idx][TB_DEPTH-1];
               r_decode_vld_p1 <= 1'b1;
            end
         end
      end
   end

   assign decode_sig       = r_decode_p1;
   assign decode_valid_sig = r_decode_vld_p1;

endmodule

// File: tb/tb_decode_viterbi.sv
// Directed and random checks of decode_viterbi with default parameters (TB_DEPTH=10, METRIC_W=6).
module tb_decode_viterbi;

   localparam int TB_DEPTH = 10;
   localparam int METRIC_W = 6;

   logic       clk_sig = 1'b0;
   logic       reset_sig = 1'b1;
   logic [1:0] encode_sig = 2'b00;
   logic       valid_sig = 1'b0;
   logic       decode_sig;
   logic       decode_valid_sig;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sig = ~clk_sig;

   decode_viterbi #(.TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W)) dut (
      .clk_sig          (clk_sig),
      .reset_sig        (reset_sig),
      .encode_sig       (encode_sig),
      .valid_sig        (valid_sig),
      .decode_sig       (decode_sig),
      .decode_valid_sig (decode_valid_sig)
   );

   // Input bits 1,0,1,1 then zeros, and the (7,5) encoding of that stream.
   function automatic logic bit_a(input int i);
      return (i == 0) || (i == 2) || (i == 3);
   endfunction

   function automatic logic [1:0] sym_a(input int i);
      case (i)
         0:       return 2'b11;
         1:       return 2'b10;
         2:       return 2'b00;
         3:       return 2'b01;
         4:       return 2'b01;
         5:       return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Same stream preceded by one zero bit.
   function automatic logic bit_b(input int i);
      return (i == 0) ? 1'b0 : bit_a(i - 1);
   endfunction

   function automatic logic [1:0] sym_b(input int i);
      return (i == 0) ? 2'b00 : sym_a(i - 1);
   endfunction

   task automatic step(input logic v, input logic [1:0] s);
      valid_sig  = v;
      encode_sig = s;
      @(posedge clk_sig);
      #1;
   endtask

   task automatic apply_reset();
      valid_sig  = 1'b0;
      encode_sig = 2'b00;
      reset_sig  = 1'b1;
      @(posedge clk_sig);
      @(posedge clk_sig);
      #1;
      reset_sig = 1'b0;
   endtask

   task automatic test_reset();
      reset_sig  = 1'b1;
      valid_sig  = 1'b1;
      encode_sig = 2'b11;
      @(posedge clk_sig);
      #1;
      checks++;
      if (decode_sig !== 1'b0 || decode_valid_sig !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got dec=%b vld=%b, want 0 0", decode_sig, decode_valid_sig);
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (dut.r_metric[j] !== ((j == 0) ? 6'd0 : 6'd32)) begin
            failures++;
            $display("FAIL reset_metric[%0d]: got %0d, want %0d", j, dut.r_metric[j], (j == 0) ? 0 : 32);
         end
         checks++;
         if (dut.r_surv[j] !== '0) begin
            failures++;
            $display("FAIL reset_surv[%0d]: got %h, want 0", j, dut.r_surv[j]);
         end
      end
      checks++;
      if (dut.r_fill !== 5'd0) begin
         failures++;
         $display("FAIL reset_fill: got %0d, want 0", dut.r_fill);
      end
      valid_sig = 1'b0;
      reset_sig = 1'b0;
   endtask

   task automatic test_all_zero();
      int pulses = 0;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 2'b00);
         if (decode_valid_sig === 1'b1) pulses++;
         checks++;
         if (decode_valid_sig !== (i >= TB_DEPTH)) begin
            failures++;
            $display("FAIL zero_vld[%0d]: got %b, want %b", i, decode_valid_sig, i >= TB_DEPTH);
         end
         if (i >= TB_DEPTH) begin
            checks++;
            if (decode_sig !== 1'b0) begin
               failures++;
               $display("FAIL zero_dec[%0d]: got %b, want 0", i, decode_sig);
            end
         end
      end
      checks++;
      if (pulses != 30) begin
         failures++;
         $display("FAIL zero_pulses: got %0d, want 30", pulses);
      end
   endtask

   task automatic test_known_seq(input logic flip_second);
      logic [1:0] s;
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         s = sym_a(i);
         if (flip_second && i == 1) s[1] = ~s[1];
         step(1'b1, s);
         checks++;
         if (decode_valid_sig !== (i >= TB_DEPTH)) begin
            failures++;
            $display("FAIL seq_vld[%0d] flip=%b: got %b, want %b", i, flip_second, decode_valid_sig, i >= TB_DEPTH);
         end
         if (i >= TB_DEPTH) begin
            checks++;
            if (decode_sig !== bit_a(i - TB_DEPTH)) begin
               failures++;
               $display("FAIL seq_dec[%0d] flip=%b: got %b, want %b", i, flip_second, decode_sig, bit_a(i - TB_DEPTH));
            end
         end
      end
      step(1'b0, 2'b11);
      checks++;
      if (decode_valid_sig !== 1'b0 || decode_sig !== bit_a(13)) begin
         failures++;
         $display("FAIL seq_idle flip=%b: got dec=%b vld=%b, want %b 0", flip_second, decode_sig, decode_valid_sig, bit_a(13));
      end
   endtask

   task automatic test_gapped();
      logic last;
      apply_reset();
      last = 1'b0;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, sym_a(i));
         if (i >= TB_DEPTH) last = bit_a(i - TB_DEPTH);
         checks++;
         if (decode_valid_sig !== (i >= TB_DEPTH) || decode_sig !== last) begin
            failures++;
            $display("FAIL gap_accept[%0d]: got dec=%b vld=%b, want %b %b", i, decode_sig, decode_valid_sig, last, i >= TB_DEPTH);
         end
         for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b11);
            checks++;
            if (decode_valid_sig !== 1'b0 || decode_sig !== last) begin
               failures++;
               $display("FAIL gap_idle[%0d.%0d]: got dec=%b vld=%b, want %b 0", i, k, decode_sig, decode_valid_sig, last);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         step(1'b1, sym_b(i));
      end
      checks++;
      if (decode_valid_sig !== 1'b1 || decode_sig !== bit_b(4)) begin
         failures++;
         $display("FAIL mid_before: got dec=%b vld=%b, want %b 1", decode_sig, decode_valid_sig, bit_b(4));
      end
      reset_sig  = 1'b1;
      valid_sig  = 1'b1;
      encode_sig = 2'b11;
      #1;
      checks++;
      if (decode_valid_sig !== 1'b0 || decode_sig !== 1'b0) begin
         failures++;
         $display("FAIL mid_async: got dec=%b vld=%b, want 0 0", decode_sig, decode_valid_sig);
      end
      @(posedge clk_sig);
      #1;
      valid_sig = 1'b0;
      reset_sig = 1'b0;
      #1;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, sym_a(i));
         checks++;
         if (decode_valid_sig !== (i >= TB_DEPTH)) begin
            failures++;
            $display("FAIL mid_vld[%0d]: got %b, want %b", i, decode_valid_sig, i >= TB_DEPTH);
         end
         if (i >= TB_DEPTH) begin
            checks++;
            if (decode_sig !== bit_a(i - TB_DEPTH)) begin
               failures++;
               $display("FAIL mid_dec[%0d]: got %b, want %b", i, decode_sig, bit_a(i - TB_DEPTH));
            end
         end
      end
   endtask

   task automatic test_stress();
      logic       hist [2000];
      logic [1:0] st;
      logic [1:0] sym;
      logic       q;
      int         raw_err = 0;
      int         dec_err = 0;
      int         mmin;
      logic       mx;
      apply_reset();
      st = 2'b00;
      for (int i = 0; i < 2000; i++) begin
         q       = 1'($urandom_range(1, 0));
         hist[i] = q;
         sym     = {q ^ st[1] ^ st[0], q ^ st[0]};
         st      = {q, st[1]};
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(99, 0) < 10) begin
               sym[b] = ~sym[b];
               raw_err++;
            end
         end
         step(1'b1, sym);
         checks++;
         if (decode_valid_sig !== (i >= TB_DEPTH) || ^decode_sig === 1'bx) begin
            failures++;
            $display("FAIL stress_out[%0d]: got dec=%b vld=%b, want known %b", i, decode_sig, decode_valid_sig, i >= TB_DEPTH);
         end
         if (i >= TB_DEPTH && decode_sig !== hist[i - TB_DEPTH]) dec_err++;
         mmin = 1 << METRIC_W;
         mx   = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (^dut.r_metric[j] === 1'bx) mx = 1'b1;
            else if (int'(dut.r_metric[j]) < mmin) mmin = int'(dut.r_metric[j]);
         end
         checks++;
         if (mx || mmin != 0) begin
            failures++;
            $display("FAIL stress_metric[%0d]: got min=%0d x=%b, want min=0 x=0", i, mmin, mx);
         end
      end
      checks++;
      if (!(dec_err * 4000 < raw_err * (2000 - TB_DEPTH))) begin
         failures++;
         $display("FAIL stress_ber: got dec_err=%0d/%0d, want below raw %0d/4000", dec_err, 2000 - TB_DEPTH, raw_err);
      end
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_known_seq(1'b0);
      test_known_seq(1'b1);
      test_gapped();
      test_reset_midstream();
      test_stress();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
